// File: rtl/mac_pkg.sv
// Shared definitions for the SIMD multiply-accumulate pipeline.
//   - default parameter values for operand width, lane count and guard width
//   - op field layout: op[1:0] selects the operation, op[MODE_BIT] selects split mode
//   - op_code_e: operation encodings used by the pipeline and the lane datapath
package mac_pkg;

  localparam int DEF_DATA_W  = 16;
  localparam int DEF_LANES   = 2;
  localparam int DEF_GUARD_W = 8;

  localparam int OP_W     = 3;
  localparam int MODE_BIT = 2;

  typedef enum logic [1:0] {
    OP_CLR = 2'b00,
    OP_MUL = 2'b01,
    OP_MAC = 2'b10,
    OP_SAT = 2'b11
  } op_code_e;

endpackage

// File: rtl/mac_simd_pipe_if.sv
// Operand/result bundle of mac_simd_pipe.
//   master: drives in_valid, stall, op, multiplier, multiplicand; reads out_valid, result, protect
//   slave : the pipeline side (mirror of master)
interface mac_simd_pipe_if import mac_pkg::*; #(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int GUARD_W = DEF_GUARD_W
) ();

  logic                  in_valid;
  logic                  stall;
  logic [OP_W-1:0]       op;
  logic [DATA_W-1:0]     multiplier;
  logic [DATA_W-1:0]     multiplicand;
  logic                  out_valid;
  logic [2*DATA_W-1:0]   result;
  logic [GUARD_W-1:0]    protect;

  modport master (
    output in_valid, stall, op, multiplier, multiplicand,
    input  out_valid, result, protect
  );

  modport slave (
    input  in_valid, stall, op, multiplier, multiplicand,
    output out_valid, result, protect
  );

endinterface

// File: rtl/mac_lane_sat.sv
// Combinational accumulator update for one signed accumulator of GUARD_W+LOW_W bits.
//   op_code : clear / multiply / multiply-accumulate / saturate
//   acc_in  : current accumulator {guard, low}
//   prod    : signed product, LOW_W bits
//   acc_out : next accumulator value
// Used once at full width and once per lane in split mode.
module mac_lane_sat import mac_pkg::*; #(
  parameter int LOW_W   = 32,
  parameter int GUARD_W = 8
) (
  input  op_code_e                   op_code,
  input  logic [GUARD_W+LOW_W-1:0]   acc_in,
  input  logic [LOW_W-1:0]           prod,
  output logic [GUARD_W+LOW_W-1:0]   acc_out
);

  localparam int ACC_W = GUARD_W + LOW_W;

  logic [ACC_W-1:0] prod_ext;
  logic [ACC_W-1:0] sum;
  logic [ACC_W-1:0] sat_max;
  logic [ACC_W-1:0] sat_min;
  logic [ACC_W-1:0] sat_val;
  logic [GUARD_W:0] top_bits;
  logic             in_range;

  assign prod_ext = {{GUARD_W{prod[LOW_W-1]}}, prod};
  assign sum      = acc_in + prod_ext;   // wraps modulo 2**ACC_W

  assign sat_max = {{(GUARD_W+1){1'b0}}, {(LOW_W-1){1'b1}}};
  assign sat_min = {{(GUARD_W+1){1'b1}}, {(LOW_W-1){1'b0}}};

  // The value fits the low field exactly when the guard bits and the low
  // field's MSB all agree; such a value is already correctly sign-extended.
  assign top_bits = acc_in[ACC_W-1:LOW_W-1];
  assign in_range = (&top_bits) || !(|top_bits);
  assign sat_val  = in_range ? acc_in : (acc_in[ACC_W-1] ? sat_min : sat_max);

  always_comb begin
    acc_out = acc_in;
    case (op_code)
      OP_CLR:  acc_out = '0;
      OP_MUL:  acc_out = prod_ext;
      OP_MAC:  acc_out = sum;
      OP_SAT:  acc_out = sat_val;
      default: acc_out = acc_in;
    endcase
  end

endmodule

// File: rtl/mac_simd_pipe.sv
// Three-stage SIMD multiply-accumulate pipeline.
//   clk     : clock, rising edge
//   reset_n : asynchronous active-low reset, clears every stage and the outputs
//   bus     : mac_simd_pipe_if.slave
//             in_valid/op/multiplier/multiplicand in; stall freezes everything;
//             out_valid/result/protect out, where {protect,result} is the accumulator.
// Stages: S1 registers the request, S2 registers the products (full and
// per-lane), S3 updates the accumulator. A result is visible three rising
// edges after its request is sampled. In split mode each lane is an
// independent signed accumulator {protect lane, result lane} with no carry
// between lanes. A mode change does not reformat the accumulator.
// DATA_W and GUARD_W must be divisible by LANES; LANES is a power of two >= 2.
module mac_simd_pipe import mac_pkg::*; #(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int LANES   = DEF_LANES,
  parameter int GUARD_W = DEF_GUARD_W
) (
  input logic             clk,
  input logic             reset_n,
  mac_simd_pipe_if.slave  bus
);

  localparam int ACC_W  = GUARD_W + 2*DATA_W;
  localparam int LW     = DATA_W / LANES;
  localparam int GW     = GUARD_W / LANES;
  localparam int LACC_W = GW + 2*LW;

  // S1
  logic                s1_valid_reg;
  logic [OP_W-1:0]     s1_op_reg;
  logic [DATA_W-1:0]   s1_a_reg;
  logic [DATA_W-1:0]   s1_b_reg;
  // S2
  logic                s2_valid_reg;
  logic [OP_W-1:0]     s2_op_reg;
  logic [2*DATA_W-1:0] s2_full_prod_reg;
  logic [2*DATA_W-1:0] s2_lane_prod_reg;   // lane i at [i*2LW +: 2LW]
  // S3
  logic                out_valid_reg;
  logic [ACC_W-1:0]    acc_reg;

  logic [2*DATA_W-1:0] full_a_ext;
  logic [2*DATA_W-1:0] full_b_ext;
  logic [2*DATA_W-1:0] full_prod_next;
  logic [2*LW-1:0]     lane_prod_next [LANES];

  op_code_e            s2_code;
  logic                s2_split;
  logic [ACC_W-1:0]    full_acc_next;
  logic [LACC_W-1:0]   lane_acc_cur  [LANES];
  logic [LACC_W-1:0]   lane_acc_next [LANES];
  logic [ACC_W-1:0]    acc_next;

  // Sign-extend before multiplying so the truncated product is the exact
  // signed product.
  assign full_a_ext     = {{DATA_W{s1_a_reg[DATA_W-1]}}, s1_a_reg};
  assign full_b_ext     = {{DATA_W{s1_b_reg[DATA_W-1]}}, s1_b_reg};
  assign full_prod_next = full_a_ext * full_b_ext;

  assign s2_code  = op_code_e'(s2_op_reg[1:0]);
  assign s2_split = s2_op_reg[MODE_BIT];

  mac_lane_sat #(
    .LOW_W   (2*DATA_W),
    .GUARD_W (GUARD_W)
  ) u_full (
    .op_code (s2_code),
    .acc_in  (acc_reg),
    .prod    (s2_full_prod_reg),
    .acc_out (full_acc_next)
  );

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      logic [2*LW-1:0] a_ext;
      logic [2*LW-1:0] b_ext;

      assign a_ext = {{LW{s1_a_reg[gi*LW+LW-1]}}, s1_a_reg[gi*LW +: LW]};
      assign b_ext = {{LW{s1_b_reg[gi*LW+LW-1]}}, s1_b_reg[gi*LW +: LW]};
      assign lane_prod_next[gi] = a_ext * b_ext;

      assign lane_acc_cur[gi] = {acc_reg[2*DATA_W + gi*GW +: GW],
                                 acc_reg[gi*2*LW +: 2*LW]};

      mac_lane_sat #(
        .LOW_W   (2*LW),
        .GUARD_W (GW)
      ) u_lane (
        .op_code (s2_code),
        .acc_in  (lane_acc_cur[gi]),
        .prod    (s2_lane_prod_reg[gi*2*LW +: 2*LW]),
        .acc_out (lane_acc_next[gi])
      );
    end
  endgenerate

  // Scatter each lane's {guard, low} back into the {protect, result} layout.
  always_comb begin
    acc_next = full_acc_next;
    if (s2_split) begin
      for (int i = 0; i < LANES; i++) begin
        acc_next[i*2*LW +: 2*LW]        = lane_acc_next[i][2*LW-1:0];
        acc_next[2*DATA_W + i*GW +: GW] = lane_acc_next[i][LACC_W-1:2*LW];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_reg     <= 1'b0;
      s1_op_reg        <= '0;
      s1_a_reg         <= '0;
      s1_b_reg         <= '0;
      s2_valid_reg     <= 1'b0;
      s2_op_reg        <= '0;
      s2_full_prod_reg <= '0;
      s2_lane_prod_reg <= '0;
      out_valid_reg    <= 1'b0;
      acc_reg          <= '0;
    end else if (!bus.stall) begin
      s1_valid_reg     <= bus.in_valid;
      s1_op_reg        <= bus.op;
      s1_a_reg         <= bus.multiplier;
      s1_b_reg         <= bus.multiplicand;

      s2_valid_reg     <= s1_valid_reg;
      s2_op_reg        <= s1_op_reg;
      s2_full_prod_reg <= full_prod_next;
      for (int i = 0; i < LANES; i++) begin
        s2_lane_prod_reg[i*2*LW +: 2*LW] <= lane_prod_next[i];
      end

      out_valid_reg    <= s2_valid_reg;
      if (s2_valid_reg) begin
        acc_reg <= acc_next;
      end
    end
  end

  assign bus.out_valid = out_valid_reg;
  assign bus.result    = acc_reg[2*DATA_W-1:0];
  assign bus.protect   = acc_reg[ACC_W-1:2*DATA_W];

endmodule

// File: doc/mac_simd_pipe.md
MAC_SIMD_PIPE -- requirements
Module: mac_simd_pipe

Interface
REQ-001 Parameter DATA_W, default 16, operand width in bits; SHALL be divisible by LANES.
REQ-002 Parameter LANES, default 2, lane count in split mode; SHALL be a power of two and at least 2.
REQ-003 Parameter GUARD_W, default 8, total guard (protect) bits; SHALL be divisible by LANES.
REQ-004 clk  input  1  clock; all state SHALL update on the rising edge.
REQ-005 reset_n  input  1  reset, asynchronous, active-low.
REQ-006 in_valid  input  1  operands and op are valid this cycle.
REQ-007 stall  input  1  freeze the whole pipeline.
REQ-008 op  input  3  op[1:0]: 00 clear, 01 multiply, 10 multiply-accumulate, 11 saturate; op[2]: 0 full-width, 1 split.
REQ-009 multiplier  input  DATA_W  signed operand A.
REQ-010 multiplicand  input  DATA_W  signed operand B.
REQ-011 out_valid  output  1  result/protect updated by a valid op.
REQ-012 result  output  2*DATA_W  accumulator low field.
REQ-013 protect  output  GUARD_W  accumulator guard field.

Function
REQ-014 Accumulator SHALL be {protect,result}, ACC_W = GUARD_W+2*DATA_W bits, held in the output stage.
REQ-015 Lane constants: LW=DATA_W/LANES, GW=GUARD_W/LANES; lane i SHALL use operand bits [(i+1)LW-1:iLW], result bits [(i+1)2LW-1:i2LW], protect bits [(i+1)GW-1:iGW].
REQ-016 Full mode SHALL treat the accumulator as one signed ACC_W value; split mode SHALL treat each lane as an independent signed (GW+2LW)-bit value with no carry between lanes.
REQ-017 Pipeline: S1 registers op/operands/valid; S2 registers signed products (full or per-lane); S3 updates the accumulator; result is visible 3 rising edges after in_valid is sampled.
REQ-018 Clear SHALL zero the accumulator (all lanes); multiply SHALL load the sign-extended product; MAC SHALL add the sign-extended product to the current accumulator.
REQ-019 Addition SHALL wrap modulo the accumulator (lane) width; no overflow flag.
REQ-020 Saturate SHALL clamp each value to the signed range of its low field (2*DATA_W full, 2LW per lane) and set its guard bits to the sign of the clamped value; in-range values are only re-sign-extended.
REQ-021 Back-to-back MAC/saturate ops SHALL see the accumulator updated by the immediately preceding op (no bubbles required).
REQ-022 Mode change SHALL NOT reformat the accumulator; bits are reinterpreted as-is.
REQ-023 in_valid=0 SHALL propagate as a bubble: accumulator unchanged, out_valid=0 at S3.
REQ-024 stall=1 SHALL hold every pipeline register, the accumulator and out_valid; inputs that cycle are ignored.
REQ-025 Stall and a valid input in the same cycle: the input SHALL be dropped; the source re-presents it.

Reset
REQ-026 reset_n low SHALL asynchronously clear all pipeline stages, result, protect and out_valid to 0, including mid-operation; in-flight ops are discarded.
REQ-027 First op accepted SHALL be the first in_valid sampled on a rising edge with reset_n high and stall low.

Structure
REQ-028 Shared package mac_pkg SHALL hold the op encodings (OP_CLR, OP_MUL, OP_MAC, OP_SAT), the mode-bit index and default parameter values.
REQ-029 One sub-module mac_lane_sat (per-lane sign-extend, add, saturate, width-parameterised) SHALL be instantiated LANES times for split mode and once at full width.

Verification (DATA_W=16, LANES=2, GUARD_W=8)
REQ-030 Full mul 0x7FFF*0x7FFF -> 3 cycles later result=0x3FFF0001, protect=0x00, out_valid=1.
REQ-031 Full mul then two MACs of 0x8000*0x8000 -> result=0xC0000000, protect=0x00; then saturate -> result=0x7FFFFFFF, protect=0x00.
REQ-032 Split mul 0x7F80*0x7F80 -> result=0x3F014000, protect=0x00 (lane1 16129, lane0 16384).
REQ-033 Split mul then two MACs of 0x0080*0x007F -> lane0=-48768, result[15:0]=0x4180, protect[3:0]=0xF; saturate -> result[15:0]=0x8000, protect[3:0]=0xF; lane1 stays 0.
REQ-034 stall high for 4 cycles mid-MAC stream -> outputs frozen, stalled-cycle inputs dropped, final sum excludes them.
REQ-035 reset_n pulsed low with 3 ops in flight -> result=0, protect=0, out_valid=0 immediately; no stale output after release.
